axil_led_regs: RTL and testbench
================================

# axil_led_regs

AXI4-Lite slave register block that sits directly upstream of the LED controller. It decodes register writes into a validated command (mode, 4-bit data) and presents it on `o_dvalid`, `o_mode` and `o_data`. It also exposes command/status readback to the AXI-Lite master driven by the UART bridge.

## Interface
- `ADDR_W`, 4: AXI-Lite address width; word-aligned, bits [1:0] ignored.
- `DATA_W`, 32: AXI-Lite data width; fixed at 32.
- `i_axi_aclk_100MHZ`  in  1  system clock.
- `i_rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `i_awaddr`/`i_awvalid`, `o_awready`  in/in/out  ADDR_W/1/1  write address channel.
- `i_wdata`/`i_wstrb`/`i_wvalid`, `o_wready`  in/in/in/out  32/4/1/1  write data channel.
- `o_bresp`/`o_bvalid`, `i_bready`  out/out/in  2/1/1  write response channel.
- `i_araddr`/`i_arvalid`, `o_arready`  in/in/out  ADDR_W/1/1  read address channel.
- `o_rdata`/`o_rresp`/`o_rvalid`, `i_rready`  out/out/out/in  32/2/1/1  read data channel.
- `o_dvalid`  out  1  one-cycle command strobe to the LED controller.
- `o_mode`  out  3  command mode; held between strobes.
- `o_data`  out  4  command data; held between strobes.

## Operation
- Register map:
  - 0x0 CMD (RW): [2:0] mode, [7:4] data.
  - 0x4 STATUS (RO): [7:0] accepted-command count, [15:8] rejected-command count. Both counters wrap at 255→0.
  - 0x8 SCRATCH (RW, 32 bit, honours all WSTRB lanes).
  - 0xC and above: unmapped.
- Write FSM states:
  - W_IDLE: `o_awready`=`o_wready`=1. AW and W may handshake in either order or in the same cycle. Each channel's ready drops once that channel is captured.
  - W_RESP: entered the cycle after both channels are captured. `o_bvalid`=1 with `o_bresp` held until `i_bready`; then return to W_IDLE.
- CMD write outcomes:
  - `wstrb[0]`=1 and mode in 1..4: update CMD, pulse `o_dvalid`, increment accepted count, OKAY.
  - `wstrb[0]`=1 and mode in {0,5,6,7}: CMD unchanged, no strobe, increment rejected count, SLVERR.
  - `wstrb[0]`=0: no effect, OKAY.
- Write to STATUS: SLVERR, no effect.
- Unmapped write or read: DECERR; read data is 0.
- Read FSM states:
  - R_IDLE: `o_arready`=1.
  - R_DATA: `o_rdata`/`o_rresp` held with `o_rvalid`=1 until `i_rready`; then return to R_IDLE.
- Read and write paths are independent and may be active concurrently.

## Timing
- Reset values:
  - `o_awready`, `o_wready`, `o_arready`, `o_bvalid`, `o_rvalid`, `o_dvalid` = 0.
  - `o_bresp`, `o_rresp`, `o_rdata`, `o_mode`, `o_data` = 0.
  - CMD, SCRATCH and both counters = 0.
  - Readies rise the first cycle after `i_rst` deasserts.
- Write: the last of the AW/W handshakes completes at edge N. At edge N+1, the register is updated, `o_bvalid` rises and `o_dvalid` pulses high for exactly one cycle. `o_mode`/`o_data` take their new values at that same edge.
- Back-to-back writes: the next AW/W is accepted no earlier than the cycle after the B handshake. Minimum 3 cycles per write.
- Read: AR handshake at edge N; `o_rvalid` at N+1. Data is sampled at N, so a write committing at edge N is not visible.
- `i_rst` asserted mid-transaction: both FSMs return to idle, outputs reset, pending responses are dropped.

## Configuration
- `AXIL_LED_STATUS_EN`:
  - Defined: STATUS register and both counters are present.
  - Undefined: counters are not built, and 0x4 behaves as unmapped (DECERR on read and write).

## Structure
- Package `axil_led_pkg` holds:
  - register offsets (`CMD`, `STATUS`, `SCRATCH`);
  - mode constants (DISPLAY=1, SHIFT=2, BLINK=3, MODN=4);
  - response codes (OKAY=0, SLVERR=2, DECERR=3);
  - write/read FSM state typedefs.
- Sub-module `axil_led_wr_capture`: AW/W independent capture and B response FSM, instantiated once.

## Test plan
- Write 0x0 = 0x0000_0052, `wstrb`=0xF → BRESP OKAY, one-cycle `o_dvalid`, `o_mode`=2, `o_data`=5; read 0x0 → 0x52.
- Write 0x0 = 0x0000_0037 → SLVERR, no `o_dvalid`, `o_mode`/`o_data` unchanged; STATUS[15:8]=1.
- W presented 3 cycles before AW, with `i_bready` held low 4 cycles → single response held stable, exactly one `o_dvalid` pulse.
- 256 valid CMD writes → STATUS[7:0] wraps to 0; write 0x4 → SLVERR; read 0x10 → DECERR, `rdata`=0.
- Read 0x8 while a SCRATCH write of 0xDEADBEEF commits on the AR edge → old value returned; next read → 0xDEADBEEF.
- Assert `i_rst` with `o_bvalid` pending → `o_bvalid`=0 and all outputs 0 after the reset edge.

Source files
------------

// File: rtl/axil_led_pkg.sv
// Shared definitions for the AXI4-Lite LED command register block.
// Latency: n/a (constants, types and pure helper functions only).
// Backpressure: n/a.
package axil_led_pkg;

    // Byte offsets of the mapped registers
    localparam logic [7:0] CMD     = 8'h00;
    localparam logic [7:0] STATUS  = 8'h04;
    localparam logic [7:0] SCRATCH = 8'h08;

    // LED controller command modes; anything outside DISPLAY..MODN is rejected
    localparam logic [2:0] DISPLAY = 3'd1;
    localparam logic [2:0] SHIFT   = 3'd2;
    localparam logic [2:0] BLINK   = 3'd3;
    localparam logic [2:0] MODN    = 3'd4;

    // AXI response codes
    localparam logic [1:0] OKAY    = 2'd0;
    localparam logic [1:0] SLVERR  = 2'd2;
    localparam logic [1:0] DECERR  = 2'd3;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    typedef enum logic [1:0] {REG_CMD, REG_STATUS, REG_SCRATCH, REG_NONE} reg_sel_t;

    // Word-aligned decode; the two byte-offset bits are ignored
    function automatic reg_sel_t decode_addr(input logic [31:0] addr);
        logic [31:0] word;
        word = addr & 32'hFFFF_FFFC;
        if (word == {24'h0, CMD})          return REG_CMD;
        else if (word == {24'h0, STATUS})  return REG_STATUS;
        else if (word == {24'h0, SCRATCH}) return REG_SCRATCH;
        else                               return REG_NONE;
    endfunction

    function automatic logic mode_valid(input logic [2:0] m);
        return (m >= DISPLAY) && (m <= MODN);
    endfunction

endpackage

// File: rtl/axil_led_wr_capture.sv
// Captures AW and W independently (any order) and runs the B response handshake.
// Latency: commit one cycle after the later AW/W handshake; BVALID rises with the commit.
// Backpressure: AWREADY/WREADY stay low from capture until BREADY accepts the response.
module axil_led_wr_capture
    import axil_led_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    output logic              commit,
    output logic [ADDR_W-1:0] cap_addr,
    output logic [31:0]       cap_data,
    output logic [3:0]        cap_strb,
    input  logic [1:0]        commit_resp
);

    wr_state_t  state, state_nxt;
    logic       aw_done, w_done, aw_done_nxt, w_done_nxt;
    logic       live;
    logic       aw_hs, w_hs;
    logic [1:0] bresp_q;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign bresp = bresp_q;

    // State register, per-channel capture flags and the response latched at commit
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= W_IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            live    <= 1'b0;
            bresp_q <= 2'b00;
        end else begin
            live    <= 1'b1;
            state   <= state_nxt;
            aw_done <= aw_done_nxt;
            w_done  <= w_done_nxt;
            if (commit) bresp_q <= commit_resp;
        end
    end

    // Payload registers, loaded on their own channel handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_addr <= '0;
            cap_data <= '0;
            cap_strb <= '0;
        end else begin
            if (aw_hs) cap_addr <= awaddr;
            if (w_hs) begin
                cap_data <= wdata;
                cap_strb <= wstrb;
            end
        end
    end

    // Next state: both channels captured moves to RESP, BREADY returns to IDLE
    always_comb begin
        state_nxt   = state;
        aw_done_nxt = aw_done;
        w_done_nxt  = w_done;
        case (state)
            W_IDLE: begin
                if (aw_done && w_done) begin
                    state_nxt   = W_RESP;
                    aw_done_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                end else begin
                    if (aw_hs) aw_done_nxt = 1'b1;
                    if (w_hs)  w_done_nxt  = 1'b1;
                end
            end
            W_RESP:  if (bready) state_nxt = W_IDLE;
            default: state_nxt = W_IDLE;
        endcase
    end

    // Outputs: readies held low in reset cycle via live, commit is the cycle before RESP
    always_comb begin
        awready = live && (state == W_IDLE) && !aw_done;
        wready  = live && (state == W_IDLE) && !w_done;
        bvalid  = (state == W_RESP);
        commit  = (state == W_IDLE) && aw_done && w_done;
    end

endmodule

// File: rtl/axil_led_regs.sv
// AXI4-Lite CMD/STATUS/SCRATCH registers feeding the LED controller; STATUS built only with AXIL_LED_STATUS_EN.
// Latency: write commits (and o_dvalid pulses) one cycle after the later AW/W handshake; read data one cycle after AR.
// Backpressure: one write and one read outstanding; readies drop until the B/R response is taken.
module axil_led_regs
    import axil_led_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              i_axi_aclk_100MHZ,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_awaddr,
    input  logic              i_awvalid,
    output logic              o_awready,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [3:0]        i_wstrb,
    input  logic              i_wvalid,
    output logic              o_wready,
    output logic [1:0]        o_bresp,
    output logic              o_bvalid,
    input  logic              i_bready,
    input  logic [ADDR_W-1:0] i_araddr,
    input  logic              i_arvalid,
    output logic              o_arready,
    output logic [DATA_W-1:0] o_rdata,
    output logic [1:0]        o_rresp,
    output logic              o_rvalid,
    input  logic              i_rready,
    output logic              o_dvalid,
    output logic [2:0]        o_mode,
    output logic [3:0]        o_data
);

    logic              clk;
    logic              wr_commit;
    logic [ADDR_W-1:0] cap_addr;
    logic [31:0]       cap_data;
    logic [3:0]        cap_strb;
    logic [1:0]        wr_resp;
    logic              cmd_we, cmd_rej, scratch_we;
    reg_sel_t          wr_sel, rd_sel;
    logic [2:0]        mode_q;
    logic [3:0]        data_q;
    logic [31:0]       scratch_q;
    logic              dvalid_q;
    rd_state_t         rd_state, rd_state_nxt;
    logic              rd_live, ar_hs;
    logic [31:0]       rdata_q, rdata_nxt;
    logic [1:0]        rresp_q, rresp_nxt;
`ifdef AXIL_LED_STATUS_EN
    logic [7:0]        acc_cnt, rej_cnt;
`endif

    assign clk      = i_axi_aclk_100MHZ;
    assign o_mode   = mode_q;
    assign o_data   = data_q;
    assign o_dvalid = dvalid_q;
    assign o_rdata  = rdata_q;
    assign o_rresp  = rresp_q;

    axil_led_wr_capture #(.ADDR_W(ADDR_W)) u_wr (
        .clk        (clk),
        .rst        (i_rst),
        .awaddr     (i_awaddr),
        .awvalid    (i_awvalid),
        .awready    (o_awready),
        .wdata      (i_wdata),
        .wstrb      (i_wstrb),
        .wvalid     (i_wvalid),
        .wready     (o_wready),
        .bresp      (o_bresp),
        .bvalid     (o_bvalid),
        .bready     (i_bready),
        .commit     (wr_commit),
        .cap_addr   (cap_addr),
        .cap_data   (cap_data),
        .cap_strb   (cap_strb),
        .commit_resp(wr_resp)
    );

    assign wr_sel = decode_addr(32'(cap_addr));
    assign rd_sel = decode_addr(32'(i_araddr));
    assign ar_hs  = i_arvalid && o_arready;

    // Classify the captured write; enables are qualified by the commit cycle
    always_comb begin
        wr_resp    = DECERR;
        cmd_we     = 1'b0;
        cmd_rej    = 1'b0;
        scratch_we = 1'b0;
        case (wr_sel)
            REG_CMD: begin
                if (!cap_strb[0]) begin
                    wr_resp = OKAY;
                end else if (mode_valid(cap_data[2:0])) begin
                    wr_resp = OKAY;
                    cmd_we  = wr_commit;
                end else begin
                    wr_resp = SLVERR;
                    cmd_rej = wr_commit;
                end
            end
            REG_STATUS: begin
`ifdef AXIL_LED_STATUS_EN
                wr_resp = SLVERR;
`else
                wr_resp = DECERR;
`endif
            end
            REG_SCRATCH: begin
                wr_resp    = OKAY;
                scratch_we = wr_commit;
            end
            default: wr_resp = DECERR;
        endcase
    end

    // CMD and SCRATCH storage plus the one-cycle command strobe
    always_ff @(posedge clk) begin
        if (i_rst) begin
            mode_q    <= 3'd0;
            data_q    <= 4'd0;
            scratch_q <= 32'd0;
            dvalid_q  <= 1'b0;
        end else begin
            dvalid_q <= cmd_we;
            if (cmd_we) begin
                mode_q <= cap_data[2:0];
                data_q <= cap_data[7:4];
            end
            if (scratch_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (cap_strb[b]) scratch_q[8*b +: 8] <= cap_data[8*b +: 8];
                end
            end
        end
    end

`ifdef AXIL_LED_STATUS_EN
    // Accepted/rejected command counters, free-running wrap at 255
    always_ff @(posedge clk) begin
        if (i_rst) begin
            acc_cnt <= 8'd0;
            rej_cnt <= 8'd0;
        end else begin
            if (cmd_we)  acc_cnt <= acc_cnt + 8'd1;
            if (cmd_rej) rej_cnt <= rej_cnt + 8'd1;
        end
    end
`endif

    // Read state register
    always_ff @(posedge clk) begin
        if (i_rst) begin
            rd_state <= R_IDLE;
            rd_live  <= 1'b0;
        end else begin
            rd_state <= rd_state_nxt;
            rd_live  <= 1'b1;
        end
    end

    // Read next state: AR handshake enters DATA, RREADY returns to IDLE
    always_comb begin
        rd_state_nxt = rd_state;
        case (rd_state)
            R_IDLE:  if (ar_hs) rd_state_nxt = R_DATA;
            R_DATA:  if (i_rready) rd_state_nxt = R_IDLE;
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    // Read handshake outputs
    always_comb begin
        o_arready = rd_live && (rd_state == R_IDLE);
        o_rvalid  = (rd_state == R_DATA);
    end

    // Read mux; sampled at the AR edge so a same-edge write commit is not seen
    always_comb begin
        rdata_nxt = 32'd0;
        rresp_nxt = DECERR;
        case (rd_sel)
            REG_CMD: begin
                rdata_nxt = {24'd0, data_q, 1'b0, mode_q};
                rresp_nxt = OKAY;
            end
`ifdef AXIL_LED_STATUS_EN
            REG_STATUS: begin
                rdata_nxt = {16'd0, rej_cnt, acc_cnt};
                rresp_nxt = OKAY;
            end
`endif
            REG_SCRATCH: begin
                rdata_nxt = scratch_q;
                rresp_nxt = OKAY;
            end
            default: begin
                rdata_nxt = 32'd0;
                rresp_nxt = DECERR;
            end
        endcase
    end

    // Read data/response registers, held until the R handshake
    always_ff @(posedge clk) begin
        if (i_rst) begin
            rdata_q <= 32'd0;
            rresp_q <= 2'b00;
        end else if (ar_hs) begin
            rdata_q <= rdata_nxt;
            rresp_q <= rresp_nxt;
        end
    end

endmodule

// File: tb/tb_axil_led_regs.sv
// Directed bench for axil_led_regs; expectations adapt to AXIL_LED_STATUS_EN.
// Address width widened to 8 so that offsets 0x10 and above are reachable.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_axil_led_regs;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [7:0]  i_awaddr = '0, i_araddr = '0;
    logic        i_awvalid = 1'b0, i_wvalid = 1'b0, i_bready = 1'b0;
    logic        i_arvalid = 1'b0, i_rready = 1'b0;
    logic [31:0] i_wdata = '0;
    logic [3:0]  i_wstrb = '0;
    logic        o_awready, o_wready, o_bvalid, o_arready, o_rvalid, o_dvalid;
    logic [1:0]  o_bresp, o_rresp;
    logic [31:0] o_rdata;
    logic [2:0]  o_mode;
    logic [3:0]  o_data;

    int vectors = 0;
    int errors = 0;
    int dv_pulses = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (o_dvalid === 1'b1) dv_pulses++;

    axil_led_regs #(.ADDR_W(8), .DATA_W(32)) dut (
        .i_axi_aclk_100MHZ(clk),
        .i_rst    (i_rst),
        .i_awaddr (i_awaddr),
        .i_awvalid(i_awvalid),
        .o_awready(o_awready),
        .i_wdata  (i_wdata),
        .i_wstrb  (i_wstrb),
        .i_wvalid (i_wvalid),
        .o_wready (o_wready),
        .o_bresp  (o_bresp),
        .o_bvalid (o_bvalid),
        .i_bready (i_bready),
        .i_araddr (i_araddr),
        .i_arvalid(i_arvalid),
        .o_arready(o_arready),
        .o_rdata  (o_rdata),
        .o_rresp  (o_rresp),
        .o_rvalid (o_rvalid),
        .i_rready (i_rready),
        .o_dvalid (o_dvalid),
        .o_mode   (o_mode),
        .o_data   (o_data)
    );

    // W is presented wlead cycles before AW; BREADY is held low bdelay cycles after BVALID
    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int wlead, input int bdelay,
                             output logic [1:0] resp, output logic dv_at_b, output logic stable);
        int   t;
        logic aw_pend, w_pend;
        t = 0; aw_pend = 1'b1; w_pend = 1'b1; stable = 1'b1;
        @(negedge clk);
        i_wdata = d; i_wstrb = s; i_wvalid = 1'b1; i_bready = 1'b0;
        if (wlead == 0) begin i_awaddr = a; i_awvalid = 1'b1; end
        while ((aw_pend || w_pend) && t < 40) begin
            if (i_awvalid && o_awready) aw_pend = 1'b0;
            if (i_wvalid && o_wready)   w_pend  = 1'b0;
            @(negedge clk); t++;
            if (!aw_pend) i_awvalid = 1'b0;
            if (!w_pend)  i_wvalid  = 1'b0;
            if (aw_pend && !i_awvalid && t >= wlead) begin i_awaddr = a; i_awvalid = 1'b1; end
        end
        i_awvalid = 1'b0; i_wvalid = 1'b0;
        while (!o_bvalid && t < 40) begin @(negedge clk); t++; end
        vectors++;
        if (o_bvalid !== 1'b1) begin
            errors++;
            $display("FAIL wr_timeout addr=%h: bvalid=%b want 1", a, o_bvalid);
        end
        resp = o_bresp;
        dv_at_b = o_dvalid;
        repeat (bdelay) begin
            @(negedge clk);
            if (o_bvalid !== 1'b1 || o_bresp !== resp) stable = 1'b0;
        end
        i_bready = 1'b1;
        @(negedge clk);
        i_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
        int t;
        t = 0;
        @(negedge clk);
        i_araddr = a; i_arvalid = 1'b1; i_rready = 1'b1;
        while (!o_arready && t < 40) begin @(negedge clk); t++; end
        @(negedge clk);
        i_arvalid = 1'b0;
        vectors++;
        if (o_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL rd_rvalid addr=%h: rvalid=%b want 1", a, o_rvalid);
        end
        d = o_rdata; resp = o_rresp;
        @(negedge clk);
        i_rready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if ({o_awready, o_wready, o_arready, o_bvalid, o_rvalid, o_dvalid} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {o_awready, o_wready, o_arready, o_bvalid, o_rvalid, o_dvalid});
        end
        vectors++;
        if ({o_bresp, o_rresp, o_rdata, o_mode, o_data} !== 43'd0) begin
            errors++;
            $display("FAIL reset_data: bresp=%0d rresp=%0d rdata=%h mode=%0d data=%h want all 0",
                     o_bresp, o_rresp, o_rdata, o_mode, o_data);
        end
        i_rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({o_awready, o_wready, o_arready} !== 3'b111) begin
            errors++;
            $display("FAIL reset_ready_rise: got %b want 111", {o_awready, o_wready, o_arready});
        end
    endtask

    task automatic test_cmd_valid();
        logic [1:0] r; logic dv, st; logic [31:0] rd; int p0;
        p0 = dv_pulses;
        axi_write(8'h00, 32'h0000_0052, 4'hF, 0, 0, r, dv, st);
        vectors++;
        if (r !== RESP_OKAY) begin errors++; $display("FAIL cmd_ok_bresp: got %0d want %0d", r, RESP_OKAY); end
        vectors++;
        if (dv !== 1'b1) begin errors++; $display("FAIL cmd_ok_dvalid_with_bvalid: got %b want 1", dv); end
        vectors++;
        if (dv_pulses - p0 !== 1) begin errors++; $display("FAIL cmd_ok_pulses: got %0d want 1", dv_pulses - p0); end
        vectors++;
        if ({o_mode, o_data} !== {3'd2, 4'd5}) begin
            errors++; $display("FAIL cmd_ok_outputs: mode=%0d data=%h want mode=2 data=5", o_mode, o_data);
        end
        axi_read(8'h00, rd, r);
        vectors++;
        if (rd !== 32'h0000_0052 || r !== RESP_OKAY) begin
            errors++; $display("FAIL cmd_readback: got %h/%0d want 00000052/0", rd, r);
        end
    endtask

    task automatic test_cmd_reject();
        logic [1:0] r, exp_r; logic dv, st; logic [31:0] rd, exp_d; int p0;
        p0 = dv_pulses;
        axi_write(8'h00, 32'h0000_0037, 4'hF, 0, 0, r, dv, st);
        vectors++;
        if (r !== RESP_SLVERR) begin errors++; $display("FAIL cmd_rej_bresp: got %0d want %0d", r, RESP_SLVERR); end
        axi_write(8'h00, 32'h0000_0014, 4'hE, 0, 0, r, dv, st);
        vectors++;
        if (r !== RESP_OKAY) begin errors++; $display("FAIL cmd_nostrb_bresp: got %0d want %0d", r, RESP_OKAY); end
        vectors++;
        if (dv_pulses - p0 !== 0) begin errors++; $display("FAIL cmd_rej_pulses: got %0d want 0", dv_pulses - p0); end
        vectors++;
        if ({o_mode, o_data} !== {3'd2, 4'd5}) begin
            errors++; $display("FAIL cmd_rej_hold: mode=%0d data=%h want mode=2 data=5", o_mode, o_data);
        end
`ifdef AXIL_LED_STATUS_EN
        exp_d = 32'h0000_0101; exp_r = RESP_OKAY;
`else
        exp_d = 32'h0; exp_r = RESP_DECERR;
`endif
        axi_read(8'h04, rd, r);
        vectors++;
        if (rd !== exp_d || r !== exp_r) begin
            errors++; $display("FAIL status_after_rej: got %h/%0d want %h/%0d", rd, r, exp_d, exp_r);
        end
    endtask

    task automatic test_w_first_bhold();
        logic [1:0] r; logic dv, st; int p0;
        p0 = dv_pulses;
        axi_write(8'h00, 32'h0000_00A4, 4'hF, 3, 4, r, dv, st);
        vectors++;
        if (r !== RESP_OKAY || st !== 1'b1) begin
            errors++; $display("FAIL wfirst_resp: resp=%0d stable=%b want 0/1", r, st);
        end
        vectors++;
        if (dv_pulses - p0 !== 1) begin errors++; $display("FAIL wfirst_pulses: got %0d want 1", dv_pulses - p0); end
        vectors++;
        if ({o_mode, o_data} !== {3'd4, 4'hA}) begin
            errors++; $display("FAIL wfirst_outputs: mode=%0d data=%h want mode=4 data=a", o_mode, o_data);
        end
        axi_write(8'h00, 32'h0000_00F1, 4'h1, 0, 0, r, dv, st);
        vectors++;
        if (r !== RESP_OKAY || {o_mode, o_data} !== {3'd1, 4'hF}) begin
            errors++; $display("FAIL mode1: resp=%0d mode=%0d data=%h want 0/1/f", r, o_mode, o_data);
        end
        axi_write(8'h00, 32'h0000_0065, 4'hF, 0, 0, r, dv, st);
        vectors++;
        if (r !== RESP_SLVERR || {o_mode, o_data} !== {3'd1, 4'hF}) begin
            errors++; $display("FAIL mode5: resp=%0d mode=%0d data=%h want 2/1/f", r, o_mode, o_data);
        end
    endtask

    task automatic test_scratch_concurrent();
        logic [1:0] r; logic dv, st; logic [31:0] rd;
        axi_write(8'h08, 32'h1234_5678, 4'h5, 0, 0, r, dv, st);
        axi_read(8'h08, rd, r);
        vectors++;
        if (rd !== 32'h0034_0078 || r !== RESP_OKAY) begin
            errors++; $display("FAIL scratch_lanes: got %h/%0d want 00340078/0", rd, r);
        end
        @(negedge clk);
        i_awaddr = 8'h08; i_wdata = 32'hDEAD_BEEF; i_wstrb = 4'hF; i_awvalid = 1'b1; i_wvalid = 1'b1;
        @(negedge clk);
        i_awvalid = 1'b0; i_wvalid = 1'b0; i_araddr = 8'h08; i_arvalid = 1'b1;
        @(negedge clk);
        i_arvalid = 1'b0;
        vectors++;
        if (o_rvalid !== 1'b1 || o_rdata !== 32'h0034_0078 || o_bvalid !== 1'b1) begin
            errors++; $display("FAIL scratch_same_edge: rvalid=%b rdata=%h bvalid=%b want 1/00340078/1",
                               o_rvalid, o_rdata, o_bvalid);
        end
        i_rready = 1'b1; i_bready = 1'b1;
        @(negedge clk);
        i_rready = 1'b0; i_bready = 1'b0;
        axi_read(8'h08, rd, r);
        vectors++;
        if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL scratch_new: got %h want deadbeef", rd); end
    endtask

    task automatic test_mid_reset();
        logic [31:0] rd, exp_d; logic [1:0] r, exp_r;
        @(negedge clk);
        i_awaddr = 8'h00; i_wdata = 32'h0000_0013; i_wstrb = 4'hF; i_awvalid = 1'b1; i_wvalid = 1'b1;
        @(negedge clk);
        i_awvalid = 1'b0; i_wvalid = 1'b0;
        @(negedge clk);
        vectors++;
        if (o_bvalid !== 1'b1 || o_mode !== 3'd3) begin
            errors++; $display("FAIL midrst_pending: bvalid=%b mode=%0d want 1/3", o_bvalid, o_mode);
        end
        i_rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({o_awready, o_wready, o_arready, o_bvalid, o_rvalid, o_dvalid, o_bresp, o_rresp,
             o_rdata, o_mode, o_data} !== 49'd0) begin
            errors++; $display("FAIL midrst_outputs: bvalid=%b rdata=%h mode=%0d data=%h want all 0",
                               o_bvalid, o_rdata, o_mode, o_data);
        end
        i_rst = 1'b0;
        @(negedge clk);
        axi_read(8'h08, rd, r);
        vectors++;
        if (rd !== 32'h0) begin errors++; $display("FAIL midrst_scratch: got %h want 0", rd); end
`ifdef AXIL_LED_STATUS_EN
        exp_d = 32'h0; exp_r = RESP_OKAY;
`else
        exp_d = 32'h0; exp_r = RESP_DECERR;
`endif
        axi_read(8'h04, rd, r);
        vectors++;
        if (rd !== exp_d || r !== exp_r) begin
            errors++; $display("FAIL midrst_status: got %h/%0d want %h/%0d", rd, r, exp_d, exp_r);
        end
    endtask

    task automatic test_wrap();
        logic [1:0] r, exp_r; logic dv, st; logic [31:0] rd, exp_d; int p0;
        logic [7:0] i8;
        p0 = dv_pulses;
        for (int i = 0; i < 255; i++) begin
            i8 = 8'(i);
            axi_write(8'h00, {24'd0, i8[3:0], 1'b0, 3'(i8[1:0]) + 3'd1}, 4'h1, 0, 0, r, dv, st);
        end
`ifdef AXIL_LED_STATUS_EN
        exp_d = 32'h0000_00FF; exp_r = RESP_OKAY;
`else
        exp_d = 32'h0; exp_r = RESP_DECERR;
`endif
        axi_read(8'h04, rd, r);
        vectors++;
        if (rd !== exp_d || r !== exp_r) begin
            errors++; $display("FAIL wrap_255: got %h/%0d want %h/%0d", rd, r, exp_d, exp_r);
        end
        axi_write(8'h00, 32'h0000_00F4, 4'hF, 0, 0, r, dv, st);
        axi_read(8'h04, rd, r);
        vectors++;
        if (rd !== 32'h0 || r !== exp_r) begin
            errors++; $display("FAIL wrap_0: got %h/%0d want 00000000/%0d", rd, r, exp_r);
        end
        vectors++;
        if (dv_pulses - p0 !== 256) begin errors++; $display("FAIL wrap_pulses: got %0d want 256", dv_pulses - p0); end
    endtask

    task automatic test_unmapped();
        logic [1:0] r, exp_r; logic dv, st; logic [31:0] rd;
`ifdef AXIL_LED_STATUS_EN
        exp_r = RESP_SLVERR;
`else
        exp_r = RESP_DECERR;
`endif
        axi_write(8'h04, 32'h0000_FFFF, 4'hF, 0, 0, r, dv, st);
        vectors++;
        if (r !== exp_r) begin errors++; $display("FAIL status_write: got %0d want %0d", r, exp_r); end
        axi_write(8'h10, 32'h0000_0011, 4'hF, 0, 0, r, dv, st);
        vectors++;
        if (r !== RESP_DECERR || {o_mode, o_data} !== {3'd4, 4'hF}) begin
            errors++; $display("FAIL unmapped_write: resp=%0d mode=%0d data=%h want 3/4/f", r, o_mode, o_data);
        end
        axi_read(8'h10, rd, r);
        vectors++;
        if (rd !== 32'h0 || r !== RESP_DECERR) begin
            errors++; $display("FAIL read_0x10: got %h/%0d want 00000000/3", rd, r);
        end
        axi_read(8'h0C, rd, r);
        vectors++;
        if (rd !== 32'h0 || r !== RESP_DECERR) begin
            errors++; $display("FAIL read_0x0c: got %h/%0d want 00000000/3", rd, r);
        end
`ifdef AXIL_LED_STATUS_EN
        axi_read(8'h04, rd, r);
        vectors++;
        if (rd !== 32'h0 || r !== RESP_OKAY) begin
            errors++; $display("FAIL status_unchanged: got %h/%0d want 00000000/0", rd, r);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_cmd_valid();
        test_cmd_reject();
        test_w_first_bhold();
        test_scratch_concurrent();
        test_mid_reset();
        test_wrap();
        test_unmapped();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
